// File: rtl/prg_boot_loader.sv
// rtl/prg_boot_loader.sv - byte-command PRG image loader with CPU reset hold and halt detection
`timescale 1ns/1ps
module prg_boot_loader #(
  parameter int ADDR_W       = 15,
  parameter int PC_W         = 16,
  parameter int RST_HOLD     = 4,
  parameter int STALL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_run,
  input  logic [PC_W-1:0]   cpu_pc,
  output logic              busy,
  output logic              err,
  output logic              halted,
  output logic [PC_W-1:0]   halt_pc
);

  typedef enum logic [3:0] {
    S_CMD, S_A_LO, S_A_HI, S_L_LO, S_L_HI, S_DATA, S_HOLD, S_RUN, S_HALT
  } state_t;

  localparam logic [7:0]  HOLD_INIT = 8'(RST_HOLD);
  localparam logic [15:0] STALL_TOP = 16'(STALL_CYCLES - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       len;
  logic [7:0]        hold_cnt;
  logic [15:0]       stall_cnt;
  logic [PC_W-1:0]   pc_last;
  logic              pc_seen;
  logic              accept;

  assign s_ready = (state != S_HOLD) && (state != S_RUN) && (state != S_HALT);
  assign busy    = (state != S_CMD) && (state != S_RUN) && (state != S_HALT);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_CMD;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      err       <= 1'b0;
      halted    <= 1'b0;
      halt_pc   <= '0;
      addr      <= '0;
      len       <= '0;
      hold_cnt  <= '0;
      stall_cnt <= '0;
      pc_last   <= '0;
      pc_seen   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_CMD: if (accept) begin
          if (s_data == 8'h01) begin
            state <= S_A_LO;
          end else if (s_data == 8'h02) begin
            state    <= S_HOLD;
            hold_cnt <= HOLD_INIT;
          end else begin
            err <= 1'b1;
          end
        end
        S_A_LO: if (accept) begin
          addr[7:0] <= s_data;
          state     <= S_A_HI;
        end
        // Upper address bits beyond the PRG window are simply truncated.
        S_A_HI: if (accept) begin
          addr  <= ADDR_W'({s_data, addr[7:0]});
          state <= S_L_LO;
        end
        S_L_LO: if (accept) begin
          len[7:0] <= s_data;
          state    <= S_L_HI;
        end
        S_L_HI: if (accept) begin
          len   <= {s_data, len[7:0]};
          state <= ({s_data, len[7:0]} == 16'd0) ? S_CMD : S_DATA;
        end
        S_DATA: if (accept) begin
          mem_we    <= 1'b1;
          mem_addr  <= addr;
          mem_wdata <= s_data;
          addr      <= addr + ADDR_W'(1);
          len       <= len - 16'd1;
          if (len == 16'd1) state <= S_CMD;
        end
        S_HOLD: begin
          if (hold_cnt == 8'd1) begin
            hold_cnt  <= '0;
            cpu_run   <= 1'b1;
            pc_seen   <= 1'b0;
            stall_cnt <= '0;
            state     <= S_RUN;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        // First RUN cycle only primes pc_last; comparisons start on the next one.
        S_RUN: begin
          pc_last <= cpu_pc;
          pc_seen <= 1'b1;
          if (pc_seen && (cpu_pc == pc_last)) begin
            if (stall_cnt == STALL_TOP) begin
              state   <= S_HALT;
              halted  <= 1'b1;
              halt_pc <= cpu_pc;
            end else begin
              stall_cnt <= stall_cnt + 16'd1;
            end
          end else begin
            stall_cnt <= '0;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_prg_boot_loader.sv
// tb/tb_prg_boot_loader.sv - scoreboard bench for prg_boot_loader
`timescale 1ns/1ps
module tb_prg_boot_loader;
  localparam int ADDR_W = 15, PC_W = 16, RST_HOLD = 4, STALL_CYCLES = 16;
  localparam longint T = 10;

  logic              clk = 1'b0, rst = 1'b1, s_valid = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic [PC_W-1:0]   cpu_pc = '0;
  logic              s_ready, mem_we, cpu_run, busy, err, halted;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [PC_W-1:0]   halt_pc;

  prg_boot_loader #(.ADDR_W(ADDR_W), .PC_W(PC_W), .RST_HOLD(RST_HOLD), .STALL_CYCLES(STALL_CYCLES)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_run(cpu_run),
    .cpu_pc(cpu_pc), .busy(busy), .err(err), .halted(halted), .halt_pc(halt_pc)
  );

  always #5 clk = ~clk;

  // kind 0 = memory write, 1 = cpu_run rise, 2 = halt; t = posedge that registers it
  typedef struct { int kind; longint t; int a; int d; } ev_t;
  ev_t          exp_q[$];
  logic [7:0]   img[$];
  logic [15:0]  pcs[$];
  int           n_cmp = 0, n_bad = 0;
  logic         prev_run = 1'b0, prev_halt = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic observe(input int kind, input longint e, input int a, input int d);
    ev_t x;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_event: got kind %0d at %0d (a=%0h d=%0h), expected none", kind, e, a, d);
    end else begin
      x = exp_q.pop_front();
      chk("event_kind", kind, x.kind);
      chk("event_time", e, x.t);
      chk("event_a", a, x.a);
      chk("event_d", d, x.d);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) observe(0, longint'($time) - 5, int'(mem_addr), int'(mem_wdata));
    if (cpu_run && !prev_run) observe(1, longint'($time) - 5, 0, 0);
    if (halted && !prev_halt) observe(2, longint'($time) - 5, int'(halt_pc), 0);
    prev_run  <= cpu_run;
    prev_halt <= halted;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, output longint t_acc);
    int w;
    w = 0;
    t_acc = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: s_ready got 0, expected 1");
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    t_acc = $time;
    #1 s_valid = 1'b0;
  endtask

  task automatic sendg(input logic [7:0] b, input bit gaps);
    longint t;
    if (gaps) idle($urandom_range(0, 2));
    send_byte(b, t);
  endtask

  // Image in img; expected address = (base + i) mod 2^ADDR_W, write lands on the acceptance edge.
  task automatic do_load(input logic [15:0] base_raw, input bit gaps, input int stop_after);
    longint t;
    int base, len;
    len  = img.size();
    base = int'(base_raw) & ((1 << ADDR_W) - 1);
    sendg(8'h01, gaps);
    sendg(base_raw[7:0], gaps);
    sendg(base_raw[15:8], gaps);
    sendg(8'(len), gaps);
    sendg(8'(len >> 8), gaps);
    for (int i = 0; i < len && i < stop_after; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send_byte(img[i], t);
      exp_q.push_back('{0, t, (base + i) % (1 << ADDR_W), int'(img[i])});
    end
  endtask

  task automatic rand_img(input int n);
    img.delete();
    repeat (n) img.push_back(8'($urandom));
  endtask

  // Halt model: count consecutive equal adjacent PC samples; halt where the count reaches STALL_CYCLES.
  task automatic do_run();
    longint t;
    int run, hidx;
    send_byte(8'h02, t);
    exp_q.push_back('{1, t + RST_HOLD * T, 0, 0});
    chk("s_ready_after_run", s_ready, 0);
    chk("busy_in_hold", busy, 1);
    run = 0;
    hidx = -1;
    for (int i = 1; i < pcs.size(); i++) begin
      run = (pcs[i] == pcs[i-1]) ? run + 1 : 0;
      if (run == STALL_CYCLES && hidx < 0) hidx = i;
    end
    if (hidx >= 0) exp_q.push_back('{2, t + (RST_HOLD + 1) * T + hidx * T, int'(pcs[hidx]), 0});
    for (int k = 0; k < RST_HOLD; k++) begin
      @(negedge clk);
      cpu_pc  = 16'($urandom);
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
    end
    for (int i = 0; i < pcs.size(); i++) begin
      @(negedge clk);
      cpu_pc  = pcs[i];
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_run"}, cpu_run, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_halt_pc"}, halt_pc, 0);
  endtask

  task automatic async_reset(input string tag, input int offset);
    @(posedge clk);
    #(offset) rst = 1'b1;
    #1 check_reset(tag);
    exp_q.delete();
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    longint t;
    idle(2);
    check_reset("reset");
    rst = 1'b0;
    idle(1);

    img = '{8'h78, 8'hA2, 8'hFF, 8'h9A, 8'hA9, 8'h00};
    do_load(16'h0000, 1'b0, 1 << 20);
    idle(2);
    chk("busy_after_load", busy, 0);

    img = '{8'h00, 8'h80, 8'h11, 8'h22, 8'h33};
    do_load(16'hFFFC, 1'b0, 1 << 20);

    send_byte(8'h05, t);
    chk("err_after_bad_cmd", err, 1);
    chk("busy_after_bad_cmd", busy, 0);
    chk("s_ready_after_bad_cmd", s_ready, 1);

    for (int n = 0; n < 6; n++) begin
      rand_img($urandom_range(1, 12));
      do_load(16'($urandom), 1'b1, 1 << 20);
    end
    rand_img(12);
    do_load(16'h7FF8, 1'b1, 1 << 20);

    img.delete();
    do_load(16'($urandom), 1'b0, 1 << 20);
    idle(2);
    chk("busy_after_len0", busy, 0);
    chk("err_sticky", err, 1);
    rand_img(3);
    do_load(16'h1234, 1'b0, 1 << 20);
    idle(3);
    chk("writes_outstanding", exp_q.size(), 0);

    // Reset lands right after the 4th byte's write strobe; that write is dropped.
    rand_img(10);
    do_load(16'($urandom), 1'b0, 4);
    #1 rst = 1'b1;
    #1 check_reset("rst_data");
    exp_q.delete();
    idle(2);
    rst = 1'b0;
    rand_img(3);
    do_load(16'h0100, 1'b1, 1 << 20);

    pcs = '{16'h8000};
    repeat (16) pcs.push_back(16'h8001);
    pcs.push_back(16'h8003);
    pcs.push_back(16'h8004);
    repeat (20) pcs.push_back(16'h8006);
    do_run();
    idle(3);
    chk("halted_run1", halted, 1);
    chk("halt_pc_run1", halt_pc, 16'h8006);
    chk("cpu_run_in_halt", cpu_run, 1);
    chk("s_ready_in_halt", s_ready, 0);
    chk("busy_in_halt", busy, 0);
    chk("err_after_ignored", err, 0);
    chk("events_outstanding_run1", exp_q.size(), 0);
    async_reset("rst_halt", 3);

    pcs.delete();
    v = 16'($urandom);
    for (int s = 0; s < 8; s++) begin
      repeat ($urandom_range(1, 18)) pcs.push_back(v);
      v = v + 16'($urandom_range(1, 3));
    end
    repeat (18) pcs.push_back(v);
    do_run();
    idle(3);
    chk("halted_run2", halted, 1);
    chk("events_outstanding_run2", exp_q.size(), 0);
    async_reset("rst_halt2", 2);

    pcs.delete();
    for (int i = 0; i < 10; i++) pcs.push_back(16'(16'h8000 + i));
    do_run();
    chk("cpu_run_before_rst", cpu_run, 1);
    chk("events_outstanding_run3", exp_q.size(), 0);
    async_reset("rst_run", 4);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
